// File: rtl/secuenciador_mac.sv
// secuenciador_mac: tap sequencer and multiply-accumulate engine for the FIR path.
//
// A sample strobe starts one output computation. The block walks the tap
// index through the coefficient ROM and sample-history RAM, multiplies each
// pair in a registered stage and sums the products in a guarded accumulator.
// When the sum is complete it is rescaled to Q10.14, saturated, and presented
// on salida with a one-cycle salida_valida pulse.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   muestra_listo  one-cycle strobe: new sample available, start a computation
//   coef, dato     synchronous memory read data (valid one cycle after addr)
//   addr, leer     tap index and read enable shared by both memories
//   ocupado        computation in progress
//   salida         saturated Q10.14 result, held until the next result
//   salida_valida  one-cycle pulse: salida updated
//   saturado       salida was clipped
//   perdida        one-cycle pulse: a strobe arrived while busy and was dropped
module secuenciador_mac #(
  parameter int N      = 25,
  parameter int FA     = 14,
  parameter int TAPS   = 5,
  parameter int ADDR_W = 3,
  parameter int G      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     muestra_listo,
  input  logic signed [N-1:0]      coef,
  input  logic signed [N-1:0]      dato,
  output logic        [ADDR_W-1:0] addr,
  output logic                     leer,
  output logic                     ocupado,
  output logic signed [N-1:0]      salida,
  output logic                     salida_valida,
  output logic                     saturado,
  output logic                     perdida
);

  localparam int ACC_W = 2*N + G;
  localparam logic signed [ACC_W-1:0] MAX_R = ACC_W'((longint'(1) << (N-1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_R = ACC_W'(-(longint'(1) << (N-1)));

  typedef enum logic [1:0] {IDLE, LECTURA, VACIADO, SALIDA} estado_t;

  estado_t                   estado_q, estado_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      leer_q, leer_d;
  logic                      vac_q, vac_d;
  logic                      perdida_q, perdida_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [N-1:0]       salida_q, salida_d;
  logic                      sat_q, sat_d;
  logic                      valido_q, valido_d;

  logic                      vld_p0;
  logic                      vld_p1;
  logic signed [2*N-1:0]     prod_p1;

  // Rescale the Q21.28 sum to Q10.14 (floor) and clip to the N-bit range.
  // Returns {saturated, value}.
  function automatic logic [N:0] satura(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> FA;
    if (r > MAX_R)
      satura = {1'b1, 1'b0, {(N-1){1'b1}}};
    else if (r < MIN_R)
      satura = {1'b1, 1'b1, {(N-1){1'b0}}};
    else
      satura = {1'b0, r[N-1:0]};
  endfunction

  always_comb begin
    estado_d  = estado_q;
    addr_d    = '0;
    leer_d    = 1'b0;
    vac_d     = 1'b0;
    acc_d     = acc_q;
    salida_d  = salida_q;
    sat_d     = sat_q;
    valido_d  = 1'b0;
    // A strobe is only lost when it lands while a computation is in flight.
    perdida_d = muestra_listo && (estado_q != IDLE);

    if (vld_p1)
      acc_d = acc_q + {{G{prod_p1[2*N-1]}}, prod_p1};

    case (estado_q)
      IDLE: begin
        if (muestra_listo) begin
          estado_d = LECTURA;
          leer_d   = 1'b1;
          acc_d    = '0;
        end
      end
      LECTURA: begin
        if (addr_q == ADDR_W'(TAPS-1)) begin
          estado_d = VACIADO;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          leer_d = 1'b1;
        end
      end
      VACIADO: begin
        // Two cycles: memory read latency plus the product register.
        vac_d = ~vac_q;
        if (vac_q)
          estado_d = SALIDA;
      end
      SALIDA: begin
        estado_d          = IDLE;
        {sat_d, salida_d} = satura(acc_q);
        valido_d          = 1'b1;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      addr_q    <= '0;
      leer_q    <= 1'b0;
      vac_q     <= 1'b0;
      perdida_q <= 1'b0;
      acc_q     <= '0;
      salida_q  <= '0;
      sat_q     <= 1'b0;
      valido_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      addr_q    <= addr_d;
      leer_q    <= leer_d;
      vac_q     <= vac_d;
      perdida_q <= perdida_d;
      acc_q     <= acc_d;
      salida_q  <= salida_d;
      sat_q     <= sat_d;
      valido_q  <= valido_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
    end else begin
      // p0: memory data for the address issued last cycle is on coef/dato
      vld_p0 <= leer_q;
      // p1: registered full-precision product
      vld_p1 <= vld_p0;
      if (vld_p0)
        prod_p1 <= (2*N)'(coef) * (2*N)'(dato);
    end
  end

  assign addr          = addr_q;
  assign leer          = leer_q;
  assign ocupado       = (estado_q != IDLE);
  assign salida        = salida_q;
  assign salida_valida = valido_q;
  assign saturado      = sat_q;
  assign perdida       = perdida_q;

endmodule

// File: doc/secuenciador_mac.md
# secuenciador_mac

- Sequencer and accumulator for the filter's fixed-point multiply-accumulate datapath.
- Start: a sample strobe from the acquisition side. The block then walks the tap index across the coefficient and sample-history memories, multiplies in a registered stage, and sums in a guarded 2N-bit accumulator.
- End: it rescales the sum to the N-bit Q10.14 format and saturates it. One result-valid pulse goes to the output/DAC stage.
- The 2N-bit product format it consumes matches the team's sign-extended Q21.28 sum representation.

## Interface

Parameters:
- N, 25, sample/coefficient width: Q10.14 signed (1 sign, 10 integer, 14 fraction bits).
- FA, 14, fractional bits of the N-bit format.
- TAPS, 5, number of taps per output sample (2..8).
- ADDR_W, 3, tap index width; TAPS ≤ 2^ADDR_W.
- G, 3, accumulator guard bits; accumulator width 2N+G.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- muestra_listo  in  1  single-cycle strobe: new sample in history, start a computation.
- coef  in  N  signed coefficient from synchronous ROM, valid 1 cycle after addr.
- dato  in  N  signed history sample from synchronous RAM, valid 1 cycle after addr.
- addr  out  ADDR_W  tap index shared by both memories.
- leer  out  1  read enable for both memories.
- ocupado  out  1  computation in progress.
- salida  out  N  saturated Q10.14 result.
- salida_valida  out  1  one-cycle pulse: salida updated.
- saturado  out  1  qualifies salida: saturation applied to this result.
- perdida  out  1  one-cycle pulse: strobe arrived while ocupado and was dropped.

## Operation

- FSM states, one per line:
  - IDLE
  - LECTURA: TAPS cycles.
  - VACIADO: 2 cycles.
  - SALIDA: 1 cycle.
- FSM transitions, one per line:
  - IDLE→LECTURA when muestra_listo=1.
  - LECTURA→VACIADO after addr=TAPS-1 issued.
  - VACIADO→SALIDA after 2 cycles.
  - SALIDA→IDLE.
- IDLE on strobe:
  - accumulator cleared.
  - addr←0, leer←1, ocupado←1.
- LECTURA: addr increments by 1 each cycle, 0..TAPS-1; leer=1. Outside LECTURA: addr=0, leer=0.
- Product stage:
  - Register p ← coef×dato, full 2N-bit signed.
  - Loaded one cycle after each valid memory read.
  - Carries a valid bit.
- Accumulator: acc ← acc + sign-extended p when product valid. No wrap for TAPS ≤ 2^G.
- SALIDA:
  - r = acc >>> FA (arithmetic shift, truncation toward −∞).
  - If r > 2^(N-1)−1: salida=0x0FFFFFF, saturado=1.
  - Else if r < −2^(N-1): salida=0x1000000, saturado=1.
  - Else: salida=r[N-1:0], saturado=0.
- salida and saturado hold until the next result.
- muestra_listo while ocupado=1:
  - Ignored; perdida pulses next cycle.
  - The computation in flight is unaffected.
- Reset asserted mid-operation:
  - Immediate return to IDLE; pipeline and accumulator cleared.
  - No salida_valida for the aborted sample.
- Reset values: addr=0, leer=0, ocupado=0, salida=0, salida_valida=0, saturado=0, perdida=0.

## Timing

- Cycle 0 = clock edge sampling muestra_listo=1 in IDLE.
- Cycles 1..TAPS: addr = k in cycle 1+k.
- Cycle 2+k: memory data for tap k valid.
- Cycle 3+k: product register holds tap k.
- End of cycle 3+k: tap k accumulated.
- Last accumulate at end of cycle TAPS+2. Cycle TAPS+3 = SALIDA.
- Cycle TAPS+4: salida_valida=1, ocupado=0, new salida visible. Total latency TAPS+4 (9 for TAPS=5).
- A strobe in cycle TAPS+4 is accepted: back-to-back throughput = one sample per TAPS+4 cycles.
- perdida asserts the cycle after the dropped strobe; width 1.

## Test plan

- Reset values: assert reset mid-idle → all outputs 0; release → no activity without strobe.
- All coef=0x0004000 (1.0), dato for tap k = k·0x0004000:
  - addr 0..4 in cycles 1..5.
  - salida=0x0028000 (10.0) in cycle 9, saturado=0, single-cycle salida_valida.
- Negative/truncation cases:
  - coef=0x1FFE000 (−0.5), dato=0x0004000 → salida=0x1FF6000 (−2.5).
  - coef=0x1FFFFFF, dato=0x0000001 → salida=0x1FFFFFF (floor of −5·2^-28).
  - coef=dato=0x0000001 → 0x0000000.
- Saturation cases:
  - coef=dato=0x0800000 (512.0) → salida=0x0FFFFFF, saturado=1.
  - coef=0x1800000, dato=0x0800000 → salida=0x1000000, saturado=1.
- Strobe handling:
  - Strobe in cycle 4 → perdida=1 in cycle 5, result in cycle 9 unchanged.
  - Strobe in cycle 9 → accepted, next result in cycle 18.
- Reset mid-run: reset low in cycle 4 → outputs zero asynchronously, no salida_valida in cycle 9. A later strobe produces a correct result.
